// File: rtl/mux_n_para_1_reg_if.sv
// mux_n_para_1_reg_if: channel inputs, selector controls and output handshake of the registered N:1 mux
interface mux_n_para_1_reg_if #(
  parameter int WIDTH = 8,
  parameter int N_ENT = 4
);
  localparam int SEL_W = $clog2(N_ENT);
  logic [N_ENT*WIDTH-1:0] in_data;
  logic [N_ENT-1:0]       in_valid;
  logic [N_ENT-1:0]       in_ready;
  logic [SEL_W-1:0]       sel;
  logic                   modo;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [SEL_W-1:0]       out_src;
  modport master (
    output in_data, in_valid, sel, modo, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );
  modport slave (
    input  in_data, in_valid, sel, modo, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/mux_n_para_1_reg.sv
// mux_n_para_1_reg: registered N:1 valid/ready mux with fixed-select or round-robin arbitration
module mux_n_para_1_reg #(
  parameter int WIDTH = 8,
  parameter int N_ENT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux_n_para_1_reg_if.slave bus
);
  localparam int SEL_W = $clog2(N_ENT);
  logic [SEL_W-1:0] ptr, grant, rr_idx, next_ptr;
  logic rr_hit, sel_ok, has_grant, can_load, xfer;
  // scan downward so the last hit written is the first valid channel at or after ptr
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = N_ENT-1; i >= 0; i--) begin
      if (bus.in_valid[(int'(ptr) + i) % N_ENT]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_W'((int'(ptr) + i) % N_ENT);
      end
    end
  end
  assign can_load     = !bus.out_valid || bus.out_ready;
  assign sel_ok       = int'(bus.sel) < N_ENT;
  assign grant        = bus.modo ? rr_idx : bus.sel;
  assign has_grant    = bus.modo ? rr_hit : sel_ok;
  assign bus.in_ready = (rst_n && has_grant && can_load) ? N_ENT'(1) << grant : '0;
  assign xfer         = |(bus.in_valid & bus.in_ready);
  assign next_ptr     = (grant == SEL_W'(N_ENT-1)) ? '0 : grant + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      ptr           <= '0;
    end else begin
      if (can_load) bus.out_valid <= xfer;
      if (xfer) begin
        bus.out_data <= bus.in_data[grant*WIDTH +: WIDTH];
        bus.out_src  <= grant;
        if (bus.modo) ptr <= next_ptr;
      end
    end
  end
endmodule
